load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory interface: MEM-stage master driving the dataMemory word port.
//  Accepts one load/store request at a time (word or byte, LDR/STR/LDRB/STRB).
//  Sequences memory cycles, including read-modify-write for byte stores, and returns a one-cycle response.
//  Sits between the pipeline MEM stage and dataMemory.
// PARAMETERS
//  DATA_W     32   data width, memory word width
//  ADDR_W     32   byte-address width of req_addr / mem_addr
//  MEM_WORDS  256  number of words in dataMemory; word index >= MEM_WORDS is an error
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  reset       in   1       synchronous, active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       high only in IDLE; accept = req_valid & req_ready
//  req_load    in   1       1 = load, 0 = store
//  req_byte    in   1       1 = byte access, 0 = word access
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   DATA_W  store data; byte store uses [7:0]
//  rsp_valid   out  1       one-cycle response pulse
//  rsp_rdata   out  DATA_W  load result (zero-extended for byte); 0 for stores/errors
//  rsp_err     out  1       qualifies rsp_valid: misaligned word or out-of-range address
//  mem_addr    out  ADDR_W  word index {2'b0, addr[ADDR_W-1:2]} -> dataMemory addr
//  mem_wdata   out  DATA_W  -> dataMemory dataIn; 0 when not writing
//  mem_rdata   in   DATA_W  <- dataMemory dataOut (valid the cycle after a read issue)
//  mem_en      out  1       -> memoryEnable
//  mem_rnw     out  1       -> readNotWrite; 1 whenever mem_en=0
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=IDLE, all request/result registers 0.
//   rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_en=0, mem_rnw=1, mem_addr=0, mem_wdata=0.
//  FSM states: IDLE, ISSUE, WAIT, WRITE, DONE. mem_* are decoded from state + latched request.
//  IDLE: req_ready=1. On accept (cycle T0), latch load/byte/addr/wdata.
//   Error check: (!byte & addr[1:0]!=0) | (addr>>2 >= MEM_WORDS) -> set err, go DONE (mem_en never asserted).
//   Otherwise go ISSUE.
//  ISSUE (T1): mem_en=1, mem_addr=word index.
//   Word store: mem_rnw=0, mem_wdata=req_wdata, -> DONE.
//   Load or byte store: mem_rnw=1 -> WAIT.
//  WAIT (T2): mem_en=0; sample mem_rdata.
//   Load: result = word, or byte lane addr[1:0] zero-extended -> DONE.
//   Byte store: merged = mem_rdata with lane addr[1:0] replaced by wdata[7:0] -> WRITE.
//  WRITE (T3): mem_en=1, mem_rnw=0, mem_wdata=merged -> DONE.
//  DONE: rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_err -> IDLE.
//   Next accept is possible the following cycle.
//  rsp_valid cycle (accept=T0): error T1; word store T2; load T3; byte store T4.
//  Byte lanes are little-endian: lane k = bits [8k+7:8k], k = addr[1:0].
//  mem_addr holds the latched index in all non-IDLE states, so dataMemory's self-rewrite of mem[addr] is benign.
//  req_* are ignored outside IDLE; requester holds req_valid until accept.
//  Reset mid-operation: at the next edge, return to IDLE with no response.
//   A write already issued in that same cycle (ISSUE word store / WRITE) still commits, because dataMemory ignores reset.
//   A byte store reset before WRITE leaves memory unchanged.
// STRUCTURE
//  lsu_pkg: state enum, MEM_WORDS default, lane-select constants.
//  Sub-module byte_lane_merge (combinational): extract zero-extended byte; merge byte into word.
//  FSM and registers stay in load_store_unit.
// TESTING
//  1. STR 0xDEADBEEF @0x10, then LDR @0x10 -> mem[4]=0xDEADBEEF; rsp_rdata=0xDEADBEEF at T3; mem_en high only at T1.
//  2. mem[4]=0x11223344; STRB 0xAB @0x11 -> mem[4]=0x1122AB44, rsp at T4.
//     Then LDRB @0x11 -> rsp_rdata=0x000000AB.
//  3. LDR @0x12 (misaligned) -> rsp_valid & rsp_err at T1, rsp_rdata=0, mem_en never asserted.
//  4. STR @0x400 (index 256) -> rsp_err=1; memory contents unchanged.
//  5. reset=0 during WAIT of STRB @0x11 -> next cycle IDLE, req_ready=1, no rsp_valid, mem[4] unchanged.
//  6. req_valid held high for LDR @0x0 then STR @0x4 -> second accept one cycle after the first rsp_valid;
//     req_ready low throughout the first request.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its byte-lane helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } lsu_state_e;

    localparam int unsigned LSU_MEM_WORDS = 256;
    localparam int unsigned LANE_W        = 8;
    localparam int unsigned LANE_SEL_W    = 2;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane helper: zero-extended byte extraction and byte-into-word merge.
module byte_lane_merge
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]     word_in,
    input  logic [LANE_SEL_W-1:0] lane,
    input  logic [LANE_W-1:0]     new_byte,
    output logic [DATA_W-1:0]     byte_ext,
    output logic [DATA_W-1:0]     merged
);

    always_comb begin
        byte_ext = '0;
        merged   = word_in;
        // Little-endian lanes: lane k occupies bits [8k+7:8k].
        for (int unsigned k = 0; k < DATA_W / LANE_W; k++) begin
            if (32'(lane) == k) begin
                byte_ext[LANE_W-1:0]       = word_in[k*LANE_W +: LANE_W];
                merged[k*LANE_W +: LANE_W] = new_byte;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage master for dataMemory: one load/store at a time, byte stores done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_rnw
);

    localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

    lsu_state_e        state_q, state_d;
    logic              load_q,  load_d;
    logic              byte_q,  byte_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic [ADDR_W-1:0] req_word_idx;
    logic              req_err;
    logic [DATA_W-1:0] lane_byte;
    logic [DATA_W-1:0] lane_merged;

    assign req_word_idx = {2'b00, req_addr[ADDR_W-1:2]};
    assign req_err      = (!req_byte && (req_addr[1:0] != 2'b00)) || (req_word_idx >= MEM_WORDS_A);

    // Index stays latched through every busy state so dataMemory never sees a stray address.
    assign mem_addr = {2'b00, addr_q[ADDR_W-1:2]};

    byte_lane_merge #(
        .DATA_W (DATA_W)
    ) u_lane (
        .word_in  (mem_rdata),
        .lane     (addr_q[LANE_SEL_W-1:0]),
        .new_byte (wdata_q[LANE_W-1:0]),
        .byte_ext (lane_byte),
        .merged   (lane_merged)
    );

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        byte_d    = byte_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_en    = 1'b0;
        mem_rnw   = 1'b1;
        mem_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load_d  = req_load;
                    byte_d  = req_byte;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                    state_d = req_err ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en = 1'b1;
                if (!load_q && !byte_q) begin
                    mem_rnw   = 1'b0;
                    mem_wdata = wdata_q;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (load_q) begin
                    rdata_d = byte_q ? lane_byte : mem_rdata;
                    state_d = ST_DONE;
                end else begin
                    // The merged word reuses the store-data register for the write-back cycle.
                    wdata_d = lane_merged;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_rnw   = 1'b0;
                mem_wdata = wdata_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
